ternary_word_sequencer: RTL and testbench

- Trit-serial controller that drives one shared single-trit ternary gate datapath (max/OR, min/AND, inverter) across multi-trit words, one trit per clock.
- Sits between a requester and the result consumer, with valid/ready handshakes on both sides.
- Trit encoding: 2'b00 = 0, 2'b01 = 1, 2'b10 = 2; 2'b11 is invalid.
- Word layout: trit k occupies bits [2k+1:2k]; trit 0 is the LSB.

---
 rtl/ternary_word_sequencer.sv | 85 ++++++++
 tb/tb_ternary_word_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ternary_word_sequencer.sv
// ternary_word_sequencer: trit-serial controller that time-shares one ternary max/min/invert gate
// across a multi-trit word, with valid/ready handshakes toward requester and consumer.
module ternary_word_sequencer #(
  parameter int TRITS = 4,
  localparam int W = 2 * TRITS,
  localparam int IW = (TRITS > 1) ? $clog2(TRITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start_valid,
  output logic          o_start_ready,
  input  logic [1:0]    i_op,
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  output logic          o_busy,
  output logic [IW-1:0] o_trit_idx,
  output logic [W-1:0]  o_result,
  output logic          o_result_valid,
  input  logic          i_result_ready,
  output logic          o_err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0]  r_a, r_b, r_result, w_next_result;
  logic [1:0]    r_op, w_ta, w_tb, w_trit;
  logic [IW-1:0] r_idx;
  logic          r_err, w_accept, w_last, w_bad;
  assign w_accept = (r_state == IDLE) && i_start_valid;
  assign w_last = r_idx == IW'(TRITS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = (r_state == IDLE) ? (i_start_valid ? ((i_op == 2'b11) ? DONE : RUN) : IDLE)
           : (r_state == RUN)  ? (w_last ? DONE : RUN)
           : (i_result_ready ? IDLE : DONE);
  end
  always_comb begin
    o_start_ready = r_state == IDLE;
    o_busy = r_state == RUN;
    o_result_valid = r_state == DONE;
    o_trit_idx = r_idx;
    o_result = r_result;
    o_err = r_err;
  end
  always_comb begin
    w_ta = '0;
    w_tb = '0;
    for (int k = 0; k < TRITS; k++) begin
      w_ta = (IW'(k) == r_idx) ? r_a[2*k +: 2] : w_ta;
      w_tb = (IW'(k) == r_idx) ? r_b[2*k +: 2] : w_tb;
    end
  end
  // b is a don't-care for NOT, so its invalid code must not raise err there
  assign w_bad = (w_ta == 2'b11) || ((r_op != 2'b10) && (w_tb == 2'b11));
  assign w_trit = w_bad ? 2'b00
                : (r_op == 2'b00) ? ((w_ta > w_tb) ? w_ta : w_tb)
                : (r_op == 2'b01) ? ((w_ta < w_tb) ? w_ta : w_tb)
                : 2'd2 - w_ta;
  always_comb begin
    w_next_result = r_result;
    for (int k = 0; k < TRITS; k++)
      w_next_result[2*k +: 2] = (IW'(k) == r_idx) ? w_trit : r_result[2*k +: 2];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_result <= '0;
      r_err <= 1'b0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_a <= i_a;
      r_b <= i_b;
      r_op <= i_op;
      r_result <= '0;
      r_err <= i_op == 2'b11;
      r_idx <= '0;
    end else if (r_state == RUN) begin
      r_result <= w_next_result;
      r_err <= r_err | w_bad;
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
endmodule

// File: tb/tb_ternary_word_sequencer.sv
// tb_ternary_word_sequencer: random and directed operations checked cycle by cycle against a word-level model.
module tb_ternary_word_sequencer;
  localparam int TRITS = 4;
  localparam int W = 2 * TRITS;
  logic clk = 0, rst = 0;
  logic i_start_valid = 0, i_result_ready = 0;
  logic [1:0] i_op = 0;
  logic [W-1:0] i_a = 0, i_b = 0;
  logic o_start_ready, o_busy, o_result_valid, o_err;
  logic [1:0] o_trit_idx;
  logic [W-1:0] o_result;
  int checks = 0, failures = 0;
  bit en = 0;
  ternary_word_sequencer #(.TRITS(TRITS)) dut (
    .clk(clk), .rst(rst), .i_start_valid(i_start_valid), .o_start_ready(o_start_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_busy(o_busy), .o_trit_idx(o_trit_idx),
    .o_result(o_result), .o_result_valid(o_result_valid), .i_result_ready(i_result_ready), .o_err(o_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int trit_of(input logic [W-1:0] w, input int k);
    return int'((w >> (2 * k)) & 3);
  endfunction
  function automatic logic [W-1:0] ref_word(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r = 0;
    if (op == 3) return 0;
    for (int k = 0; k < TRITS; k++) begin
      int x = trit_of(a, k), y = trit_of(b, k), t;
      if (x == 3 || (op != 2 && y == 3)) t = 0;
      else t = (op == 0) ? ((x > y) ? x : y) : (op == 1) ? ((x < y) ? x : y) : 2 - x;
      r = r | (W'(t) << (2 * k));
    end
    return r;
  endfunction
  function automatic logic [TRITS-1:0] ref_bad(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [TRITS-1:0] m = 0;
    for (int k = 0; k < TRITS; k++)
      m[k] = op != 3 && (trit_of(a, k) == 3 || (op != 2 && trit_of(b, k) == 3));
    return m;
  endfunction
  int m_mode, m_k;
  logic [W-1:0] m_full;
  logic [TRITS-1:0] m_bad;
  logic m_rsv;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_mode <= 0; m_k <= 0; m_full <= 0; m_bad <= 0; m_rsv <= 0;
    end else if (m_mode == 0) begin
      if (i_start_valid) begin
        m_full <= ref_word(i_op, i_a, i_b);
        m_bad <= ref_bad(i_op, i_a, i_b);
        m_rsv <= i_op == 3;
        m_k <= 0;
        m_mode <= (i_op == 3) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      m_k <= m_k + 1;
      if (m_k == TRITS - 1) m_mode <= 2;
    end else if (i_result_ready) m_mode <= 0;
  always @(negedge clk)
    if (en) begin
      logic [W-1:0] er;
      logic ee;
      er = (m_mode == 1) ? (m_full & W'((1 << (2 * m_k)) - 1)) : m_full;
      ee = (m_mode == 1) ? |(m_bad & TRITS'((1 << m_k) - 1)) : (|m_bad | m_rsv);
      chk("start_ready", o_start_ready, m_mode == 0);
      chk("busy", o_busy, m_mode == 1);
      chk("result_valid", o_result_valid, m_mode == 2);
      chk("result", o_result, er);
      chk("err", o_err, ee);
      if (m_mode == 1) chk("trit_idx", o_trit_idx, m_k);
    end
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        output logic [W-1:0] res, output logic e, output int lat);
    @(negedge clk);
    i_op = op; i_a = a; i_b = b; i_start_valid = 1;
    @(negedge clk);
    i_start_valid = 0; i_a = W'($urandom); i_b = W'($urandom); i_op = 2'($urandom);
    lat = 1;
    while (!o_result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) chk("valid_timeout", 0, 1);
    res = o_result;
    e = o_err;
    for (int h = 0; h < hold; h++) begin
      i_start_valid = 1; i_a = W'($urandom); i_b = W'($urandom);
      @(negedge clk);
      chk("held_result", o_result, res);
      chk("held_valid", o_result_valid, 1);
    end
    i_start_valid = 0;
    i_result_ready = 1;
    @(negedge clk);
    i_result_ready = 0;
    chk("idle_after_accept", o_start_ready, 1);
  endtask
  initial begin
    logic [W-1:0] res;
    logic e;
    int lat;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    en = 1;
    @(negedge clk);
    chk("reset_ready", o_start_ready, 1);
    chk("reset_result", o_result, 0);
    run_op(2'b00, 8'h92, 8'h25, 0, res, e, lat);
    chk("or_res", res, 8'hA6); chk("or_err", e, 0); chk("or_lat", lat, TRITS + 1);
    run_op(2'b01, 8'h92, 8'h25, 0, res, e, lat);
    chk("and_res", res, 8'h11); chk("and_err", e, 0);
    run_op(2'b10, 8'h92, 8'h25, 1, res, e, lat);
    chk("not_res", res, 8'h18);
    run_op(2'b10, 8'h92, 8'hFF, 0, res, e, lat);
    chk("not_bff_res", res, 8'h18); chk("not_bff_err", e, 0);
    run_op(2'b00, 8'h93, 8'h25, 0, res, e, lat);
    chk("inv_res", res, 8'hA4); chk("inv_err", e, 1);
    run_op(2'b00, 8'h92, 8'h25, 0, res, e, lat);
    chk("clear_err", e, 0);
    run_op(2'b11, 8'h92, 8'h25, 0, res, e, lat);
    chk("rsv_res", res, 8'h00); chk("rsv_err", e, 1); chk("rsv_lat", lat, 1);
    run_op(2'b01, 8'h92, 8'h25, 3, res, e, lat);
    chk("bp_res", res, 8'h11);
    @(negedge clk);
    i_op = 2'b00; i_a = 8'h92; i_b = 8'h25; i_start_valid = 1;
    @(negedge clk);
    i_start_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_ready", o_start_ready, 1);
    chk("arst_busy", o_busy, 0);
    chk("arst_result", o_result, 0);
    chk("arst_idx", o_trit_idx, 0);
    @(negedge clk);
    rst = 0;
    run_op(2'b00, 8'h92, 8'h25, 0, res, e, lat);
    chk("post_rst_or", res, 8'hA6);
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      logic [W-1:0] a = W'($urandom), b = W'($urandom);
      if ($urandom_range(0, 1) == 0)
        for (int k = 0; k < TRITS; k++) begin
          if (a[2*k +: 2] == 2'b11) a[2*k +: 2] = 2'($urandom_range(0, 2));
          if (b[2*k +: 2] == 2'b11) b[2*k +: 2] = 2'($urandom_range(0, 2));
        end
      run_op(op, a, b, $urandom_range(0, 3), res, e, lat);
      chk("rand_res", res, ref_word(op, a, b));
      chk("rand_err", e, |ref_bad(op, a, b) | (op == 3));
      chk("rand_lat", lat, (op == 3) ? 1 : TRITS + 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
